gcn_aggregate_argmax: RTL and testbench
=======================================

GCN_AGGREGATE_ARGMAX -- requirements
Module: gcn_aggregate_argmax

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 6: node count.
REQ-002 SHALL have parameter NUM_CLASSES, default 3: output classes per node.
REQ-003 SHALL have parameter MAX_EDGES, default 6: COO column depth.
REQ-004 SHALL have parameter DOT_PROD_WIDTH, default 16: width of each FM*W product element.
REQ-005 SHALL have parameter ACC_WIDTH, default DOT_PROD_WIDTH+$clog2(MAX_EDGES+1): accumulator width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request, sampled in IDLE/DONE.
- num_edges  in  $clog2(MAX_EDGES+1)  runtime edge count, sampled with start.
- self_loop  in  1  add each node's own row before edges, sampled with start.
- coo_address  out  $clog2(MAX_EDGES)  COO column index.
- coo_in  in  2*$clog2(NUM_OF_NODES)  {src,dst} of column coo_address, same cycle.
- comb_enable  out  1  combination-row read request.
- comb_address  out  $clog2(NUM_OF_NODES)  row to read.
- comb_in  in  NUM_CLASSES*DOT_PROD_WIDTH  requested row, valid the cycle after comb_enable.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  level, high in DONE.
- max_addi_answer  out  NUM_OF_NODES*$clog2(NUM_CLASSES)  per-node argmax class.
- sat_flag  out  1  sticky, any accumulator saturated this run.
- edge_err  out  1  sticky, any edge index >= NUM_OF_NODES this run.

Function
REQ-007 SHALL implement states IDLE, CLEAR, SELF_RD, SELF_ACC, EDGE_RD, EDGE_ACC, ARGMAX, DONE.
REQ-008 IDLE or DONE with start=1 SHALL go to CLEAR, latch num_edges (clamped to MAX_EDGES) and self_loop, clear sat_flag, edge_err, done.
REQ-009 CLEAR (1 cycle) SHALL zero all accumulators; next: SELF_RD if self_loop, else EDGE_RD if num_edges>0, else ARGMAX.
REQ-010 SELF_RD SHALL assert comb_enable with comb_address=n; SELF_ACC SHALL load acc[n]=comb_in; n runs 0..NUM_OF_NODES-1, then as REQ-009.
REQ-011 EDGE_RD SHALL drive coo_address=e, comb_enable=1, comb_address=src, and latch dst; EDGE_ACC SHALL do acc[dst][k]+=comb_in[k] for all k.
REQ-012 Edge with src or dst >= NUM_OF_NODES SHALL set edge_err, be skipped (no comb_enable, no EDGE_ACC), and cost 1 cycle.
REQ-013 After edge num_edges-1, SHALL go to ARGMAX.
REQ-014 Accumulation SHALL be unsigned and saturate at 2^ACC_WIDTH-1; saturation sets sat_flag.
REQ-015 ARGMAX SHALL process one node per cycle (NUM_OF_NODES cycles), writing the index of the largest acc element; ties resolve to lowest class index.
REQ-016 DONE SHALL hold done=1 and max_addi_answer stable until next start.
REQ-017 start SHALL be ignored outside IDLE/DONE.
REQ-018 Run latency, start to done: 2 + (self_loop?2*NUM_OF_NODES:0) + sum over edges (2 valid, 1 invalid) + NUM_OF_NODES cycles.
REQ-019 comb_enable SHALL be 0 outside SELF_RD/EDGE_RD; coo_address SHALL be 0 outside EDGE states.

Reset
REQ-020 reset low SHALL immediately force IDLE and zero all of: busy, done, comb_enable, comb_address, coo_address, max_addi_answer, sat_flag, edge_err, accumulators.
REQ-021 reset mid-run SHALL abort the run with no done pulse; next start runs from scratch.

Structure
REQ-022 Shared package gcn_pkg SHALL hold the state enum and node/class/edge index width helpers.
REQ-023 SHALL use one sub-module, gcn_argmax_row: combinational NUM_CLASSES-way compare with lowest-index tie rule.

Verification
REQ-024 Default params, self_loop=0, num_edges=0 -> done at cycle 8, all answers 0, flags 0.
REQ-025 Rows n=[n,2n,3n], edges (0->1),(2->1), self_loop=1 -> acc[1]=[3,6,9], answer[1]=2, done at cycle 24.
REQ-026 Two edges into node 0, each row [0xFFFF,0,0], ACC_WIDTH=16 -> acc saturates 0xFFFF, sat_flag=1, answer[0]=0.
REQ-027 Row [5,5,1] for node 3 -> answer[3]=0 (tie to lowest).
REQ-028 Edge (7->0) with num_edges=1 -> edge_err=1, no comb_enable during EDGE, run finishes.
REQ-029 reset low during EDGE_ACC -> outputs zero immediately; new start gives same results as a clean run.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and index-width helpers for the GCN aggregate/argmax block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SELF_RD,
        SELF_ACC,
        EDGE_RD,
        EDGE_ACC,
        ARGMAX,
        DONE
    } state_t;

    // Bits needed to index n items (at least one bit so ports never collapse).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/gcn_argmax_row.sv
// Combinational argmax over one accumulator row; ties pick the lowest class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, output follows input every cycle.
module gcn_argmax_row
    import gcn_pkg::*;
#(
    parameter int NUM_CLASSES = 3,
    parameter int ACC_WIDTH   = 19
) (
    input  logic [NUM_CLASSES*ACC_WIDTH-1:0] row,
    output logic [idx_w(NUM_CLASSES)-1:0]    idx
);

    localparam int CLS_W = idx_w(NUM_CLASSES);

    logic [ACC_WIDTH-1:0] best;

    // Strict greater-than keeps the earliest class on equal values.
    always_comb begin
        best = row[ACC_WIDTH-1:0];
        idx  = '0;
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (row[k*ACC_WIDTH +: ACC_WIDTH] > best) begin
                best = row[k*ACC_WIDTH +: ACC_WIDTH];
                idx  = CLS_W'(k);
            end
        end
    end

endmodule

// File: rtl/gcn_aggregate_argmax.sv
// Aggregates neighbour rows (optional self row + COO edges) per node, then argmax per node.
// Latency: 2 + (self_loop ? 2*N : 0) + 2 per valid edge + 1 per bad edge + N cycles.
// Backpressure: none; start is only honoured in IDLE/DONE, memories answer with fixed timing.
module gcn_aggregate_argmax
    import gcn_pkg::*;
#(
    parameter int NUM_OF_NODES   = 6,
    parameter int NUM_CLASSES    = 3,
    parameter int MAX_EDGES      = 6,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int ACC_WIDTH      = DOT_PROD_WIDTH + $clog2(MAX_EDGES + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [cnt_w(MAX_EDGES)-1:0]                num_edges,
    input  logic                                       self_loop,
    output logic [idx_w(MAX_EDGES)-1:0]                coo_address,
    input  logic [2*idx_w(NUM_OF_NODES)-1:0]           coo_in,
    output logic                                       comb_enable,
    output logic [idx_w(NUM_OF_NODES)-1:0]             comb_address,
    input  logic [NUM_CLASSES*DOT_PROD_WIDTH-1:0]      comb_in,
    output logic                                       busy,
    output logic                                       done,
    output logic [NUM_OF_NODES*idx_w(NUM_CLASSES)-1:0] max_addi_answer,
    output logic                                       sat_flag,
    output logic                                       edge_err
);

    localparam int NODE_W = idx_w(NUM_OF_NODES);
    localparam int CLS_W  = idx_w(NUM_CLASSES);
    localparam int EDGE_W = idx_w(MAX_EDGES);
    localparam int NE_W   = cnt_w(MAX_EDGES);
    localparam logic [NODE_W:0]   NODES_L   = (NODE_W + 1)'(NUM_OF_NODES);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_OF_NODES - 1);
    localparam logic [NE_W-1:0]   MAX_NE    = NE_W'(MAX_EDGES);

    state_t                state, state_nxt;
    logic [NODE_W-1:0]     node_q;
    logic [EDGE_W-1:0]     edge_q;
    logic [NE_W-1:0]       ne_q;
    logic                  sl_q;
    logic [NODE_W-1:0]     dst_q;
    logic [ACC_WIDTH-1:0]  acc     [NUM_OF_NODES][NUM_CLASSES];
    logic [ACC_WIDTH-1:0]  acc_add [NUM_CLASSES];
    logic [ACC_WIDTH:0]    sum_k;
    logic                  sat_hit;
    logic [NUM_CLASSES*ACC_WIDTH-1:0] arg_row;
    logic [CLS_W-1:0]      arg_idx;

    logic [NODE_W-1:0] src, dst;
    logic              edge_ok, last_node, last_edge, accept;

    assign src       = coo_in[2*NODE_W-1 -: NODE_W];
    assign dst       = coo_in[NODE_W-1:0];
    assign edge_ok   = ({1'b0, src} < NODES_L) && ({1'b0, dst} < NODES_L);
    assign last_node = (node_q == LAST_NODE);
    assign last_edge = ((NE_W'(edge_q) + NE_W'(1)) == ne_q);
    assign accept    = start && (state == IDLE || state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and memory-port decode.
    always_comb begin
        state_nxt    = state;
        comb_enable  = 1'b0;
        comb_address = '0;
        coo_address  = '0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (sl_q)           state_nxt = SELF_RD;
                else if (ne_q != 0) state_nxt = EDGE_RD;
                else                state_nxt = ARGMAX;
            end
            SELF_RD: begin
                comb_enable  = 1'b1;
                comb_address = node_q;
                state_nxt    = SELF_ACC;
            end
            SELF_ACC: begin
                if (!last_node)     state_nxt = SELF_RD;
                else if (ne_q != 0) state_nxt = EDGE_RD;
                else                state_nxt = ARGMAX;
            end
            EDGE_RD: begin
                coo_address = edge_q;
                if (edge_ok) begin
                    comb_enable  = 1'b1;
                    comb_address = src;
                    state_nxt    = EDGE_ACC;
                end else begin
                    state_nxt = last_edge ? ARGMAX : EDGE_RD;
                end
            end
            EDGE_ACC: begin
                coo_address = edge_q;
                state_nxt   = last_edge ? ARGMAX : EDGE_RD;
            end
            ARGMAX: begin
                if (last_node) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating per-class add of the returned row into the latched destination.
    always_comb begin
        sat_hit = 1'b0;
        sum_k   = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            sum_k = {1'b0, acc[dst_q][k]}
                  + (ACC_WIDTH + 1)'(comb_in[k*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
            if (sum_k[ACC_WIDTH]) begin
                acc_add[k] = '1;
                sat_hit    = 1'b1;
            end else begin
                acc_add[k] = sum_k[ACC_WIDTH-1:0];
            end
        end
    end

    // Row currently being reduced by the argmax pass.
    always_comb begin
        arg_row = '0;
        for (int k = 0; k < NUM_CLASSES; k++)
            arg_row[k*ACC_WIDTH +: ACC_WIDTH] = acc[node_q][k];
    end

    gcn_argmax_row #(
        .NUM_CLASSES (NUM_CLASSES),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_argmax (
        .row (arg_row),
        .idx (arg_idx)
    );

    // Run configuration, counters, sticky flags and answers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            node_q          <= '0;
            edge_q          <= '0;
            ne_q            <= '0;
            sl_q            <= 1'b0;
            dst_q           <= '0;
            sat_flag        <= 1'b0;
            edge_err        <= 1'b0;
            max_addi_answer <= '0;
        end else begin
            if (accept) begin
                ne_q     <= (num_edges > MAX_NE) ? MAX_NE : num_edges;
                sl_q     <= self_loop;
                sat_flag <= 1'b0;
                edge_err <= 1'b0;
            end
            case (state)
                CLEAR: begin
                    node_q <= '0;
                    edge_q <= '0;
                end
                SELF_ACC: node_q <= last_node ? '0 : node_q + NODE_W'(1);
                EDGE_RD: begin
                    dst_q <= dst;
                    if (!edge_ok) begin
                        edge_err <= 1'b1;
                        edge_q   <= last_edge ? '0 : edge_q + EDGE_W'(1);
                    end
                end
                EDGE_ACC: begin
                    if (sat_hit) sat_flag <= 1'b1;
                    edge_q <= last_edge ? '0 : edge_q + EDGE_W'(1);
                end
                ARGMAX: begin
                    max_addi_answer[node_q*CLS_W +: CLS_W] <= arg_idx;
                    node_q <= last_node ? '0 : node_q + NODE_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Accumulator array: cleared, loaded with the self row, or summed per edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_OF_NODES; n++)
                for (int k = 0; k < NUM_CLASSES; k++)
                    acc[n][k] <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    for (int n = 0; n < NUM_OF_NODES; n++)
                        for (int k = 0; k < NUM_CLASSES; k++)
                            acc[n][k] <= '0;
                end
                SELF_ACC: begin
                    for (int k = 0; k < NUM_CLASSES; k++)
                        acc[node_q][k] <= ACC_WIDTH'(comb_in[k*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
                end
                EDGE_ACC: begin
                    for (int k = 0; k < NUM_CLASSES; k++)
                        acc[dst_q][k] <= acc_add[k];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_aggregate_argmax.sv
// Directed bench: default-width DUT (a) plus a 16-bit-accumulator DUT (b) for saturation.
// Latency: measured in cycles from the start cycle (cycle 0) to first done.
// Backpressure: none; row and COO memories are modelled with fixed timing.
module tb_gcn_aggregate_argmax;
    import gcn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_edges = '0;
    logic        self_loop = 1'b0;

    logic [2:0]  coo_address_a, coo_address_b;
    logic [5:0]  coo_in_a, coo_in_b;
    logic        comb_enable_a, comb_enable_b;
    logic [2:0]  comb_address_a, comb_address_b;
    logic [47:0] comb_in_a = '0, comb_in_b = '0;
    logic        busy_a, busy_b, done_a, done_b;
    logic [11:0] ans_a, ans_b;
    logic        sat_a, sat_b, err_a, err_b;

    logic [47:0] row_mem [0:7];
    logic [5:0]  coo_mem [0:7];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gcn_aggregate_argmax u_dut_a (
        .clk (clk), .reset (rst_n), .start (start), .num_edges (num_edges),
        .self_loop (self_loop), .coo_address (coo_address_a), .coo_in (coo_in_a),
        .comb_enable (comb_enable_a), .comb_address (comb_address_a), .comb_in (comb_in_a),
        .busy (busy_a), .done (done_a), .max_addi_answer (ans_a),
        .sat_flag (sat_a), .edge_err (err_a)
    );

    gcn_aggregate_argmax #(.ACC_WIDTH(16)) u_dut_b (
        .clk (clk), .reset (rst_n), .start (start), .num_edges (num_edges),
        .self_loop (self_loop), .coo_address (coo_address_b), .coo_in (coo_in_b),
        .comb_enable (comb_enable_b), .comb_address (comb_address_b), .comb_in (comb_in_b),
        .busy (busy_b), .done (done_b), .max_addi_answer (ans_b),
        .sat_flag (sat_b), .edge_err (err_b)
    );

    assign coo_in_a = coo_mem[coo_address_a];
    assign coo_in_b = coo_mem[coo_address_b];

    // Row memories answer one cycle after the read request.
    always @(posedge clk) begin
        if (comb_enable_a) comb_in_a <= row_mem[comb_address_a];
        if (comb_enable_b) comb_in_b <= row_mem[comb_address_b];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rows_lin();
        for (int n = 0; n < 8; n++)
            row_mem[n] = {16'(3*n), 16'(2*n), 16'(n)};
    endtask

    task automatic clear_coo();
        for (int e = 0; e < 8; e++) coo_mem[e] = '0;
    endtask

    // Launch one run and count cycles (start cycle = 0) until done on DUT a.
    task automatic run_once(input logic sl, input logic [2:0] ne, input bit poke,
                            output int lat, output int ce_cnt, output logic busy1);
        @(negedge clk);
        self_loop = sl;
        num_edges = ne;
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 1;
        ce_cnt = 0;
        busy1  = busy_a;
        while (!done_a && lat < 200) begin
            if (comb_enable_a) ce_cnt++;
            if (poke) start = (lat == 3);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    int          lat, ce;
    logic        b1;
    logic [11:0] ans_keep;

    initial begin
        set_rows_lin();
        clear_coo();

        // Reset state
        #12;
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_comb_en", comb_enable_a, 0);
        check_eq("rst_comb_addr", comb_address_a, 0);
        check_eq("rst_coo_addr", coo_address_a, 0);
        check_eq("rst_answer", ans_a, 0);
        check_eq("rst_flags", {sat_a, err_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // No self loop, no edges: all-zero accumulators
        run_once(1'b0, 3'd0, 1'b0, lat, ce, b1);
        check_eq("empty_latency", lat, 8);
        check_eq("empty_busy", b1, 1);
        check_eq("empty_answer", ans_a, 12'h000);
        check_eq("empty_flags", {sat_a, err_a}, 0);
        check_eq("empty_comb_reads", ce, 0);

        // Self loop plus edges 0->1 and 2->1; a stray start mid-run is ignored
        coo_mem[0] = {3'd0, 3'd1};
        coo_mem[1] = {3'd2, 3'd1};
        run_once(1'b1, 3'd2, 1'b1, lat, ce, b1);
        check_eq("agg_latency", lat, 24);
        check_eq("agg_answer", ans_a, 12'hAA8);
        check_eq("agg_answer1", ans_a[3:2], 2);
        check_eq("agg_comb_reads", ce, 8);
        check_eq("agg_flags", {sat_a, err_a}, 0);
        ans_keep = ans_a;
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_done", done_a, 1);
        check_eq("hold_answer", ans_a, ans_keep);

        // Tie between classes 0 and 1 on node 3
        row_mem[3] = {16'd1, 16'd5, 16'd5};
        run_once(1'b1, 3'd0, 1'b0, lat, ce, b1);
        check_eq("tie_latency", lat, 20);
        check_eq("tie_answer", ans_a, 12'hA28);
        set_rows_lin();

        // Out-of-range source index: skipped in one cycle, no read
        coo_mem[0] = {3'd7, 3'd0};
        run_once(1'b0, 3'd1, 1'b0, lat, ce, b1);
        check_eq("err_latency", lat, 9);
        check_eq("err_flag", err_a, 1);
        check_eq("err_comb_reads", ce, 0);
        check_eq("err_answer", ans_a, 12'h000);

        // Two 0xFFFF rows into node 0: 16-bit accumulator saturates
        row_mem[1] = {16'd0, 16'd0, 16'hFFFF};
        row_mem[2] = {16'd0, 16'd0, 16'hFFFF};
        coo_mem[0] = {3'd1, 3'd0};
        coo_mem[1] = {3'd2, 3'd0};
        run_once(1'b0, 3'd2, 1'b0, lat, ce, b1);
        check_eq("sat_latency", lat, 12);
        check_eq("sat_flag_b", sat_b, 1);
        check_eq("sat_flag_a", sat_a, 0);
        check_eq("sat_answer_b", ans_b, 12'h000);
        check_eq("sat_err_cleared", err_a, 0);
        check_eq("sat_done_b", done_b, 1);

        // New start clears sticky flags
        run_once(1'b0, 3'd0, 1'b0, lat, ce, b1);
        check_eq("clr_sat_b", sat_b, 0);
        check_eq("clr_latency", lat, 8);

        // Reset during the first EDGE_ACC, then rerun the aggregate case
        set_rows_lin();
        coo_mem[0] = {3'd0, 3'd1};
        coo_mem[1] = {3'd2, 3'd1};
        @(negedge clk);
        self_loop = 1'b1;
        num_edges = 3'd2;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_eq("mid_busy_before", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_busy", busy_a, 0);
        check_eq("mid_done", done_a, 0);
        check_eq("mid_comb_en", comb_enable_a, 0);
        check_eq("mid_coo_addr", coo_address_a, 0);
        check_eq("mid_answer", ans_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_once(1'b1, 3'd2, 1'b0, lat, ce, b1);
        check_eq("rerun_latency", lat, 24);
        check_eq("rerun_answer", ans_a, 12'hAA8);
        check_eq("rerun_flags", {sat_a, err_a}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
